// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that hands one 24-bit frame at a time to a 3-byte UART
// frame transmitter, with completion/timeout reporting and an inter-frame gap.
module uart_frame_arbiter #(
   parameter int NREQ        = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [24*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      err,
   output logic                 tx_enable,
   output logic [23:0]          tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic [2:0]           grant_id
);

   localparam int          IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int          TW    = $clog2(TIMEOUT_CYC) + 1;
   localparam int          GW    = $clog2(GAP_CYC + 1) + 1;
   localparam int unsigned N_U   = NREQ;
   localparam int unsigned GAP_U = GAP_CYC;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        grant_q, grant_d;
   logic [23:0]       data_q, data_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic              txen_q, txen_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [NREQ-1:0]   err_q, err_d;
   logic              done_q;
   logic              done_edge;
   logic              rr_found;
   logic [IW-1:0]     rr_idx;
   logic [23:0]       slice [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign slice[g] = req_data[24*g +: 24];
   end

   assign done_edge = tx_done & ~done_q;

   // Two passes give the wrapped search order: indices above the last grant first,
   // then from 0 up to and including the last grant.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         if (!rr_found && req[i] && (i > 32'(grant_q))) begin
            rr_found = 1'b1;
            rr_idx   = IW'(i);
         end
      end
      for (int unsigned i = 0; i < N_U; i++) begin
         if (!rr_found && req[i] && (i <= 32'(grant_q))) begin
            rr_found = 1'b1;
            rr_idx   = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      txen_d  = 1'b0;
      ack_d   = '0;
      err_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               grant_d = 3'(rr_idx);
               data_d  = slice[rr_idx];
               txen_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tcnt_q != '1) tcnt_d = tcnt_q + TW'(1);
            // Completion takes precedence over a timeout landing in the same cycle.
            if (done_edge) begin
               ack_d[grant_q[IW-1:0]] = 1'b1;
               gcnt_d  = '0;
               state_d = S_GAP;
            end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d[grant_q[IW-1:0]] = 1'b1;
               gcnt_d  = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (32'(gcnt_q) + 32'd1 >= GAP_U) state_d = S_IDLE;
            else                              gcnt_d  = gcnt_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= 3'(NREQ - 1);
         data_q  <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         txen_q  <= 1'b0;
         ack_q   <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         txen_q  <= txen_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         done_q  <= tx_done;
      end
   end

   assign ack       = ack_q;
   assign err       = err_q;
   assign tx_enable = txen_q;
   assign tx_data   = data_q;
   assign busy      = (state_q != S_IDLE);
   assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: expected grants are queued as requests
// are driven and popped as frames start; outputs are sampled on the falling edge.
module tb_uart_frame_arbiter;

   localparam int NREQ = 4;
   localparam int GAP  = 4;
   localparam int TMO  = 100;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [24*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     ack, err;
   logic                tx_enable;
   logic [23:0]         tx_data;
   logic                tx_done;
   logic                busy;
   logic [2:0]          grant_id;

   typedef struct {
      logic [2:0]  id;
      logic [23:0] data;
      bit          is_err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   uart_frame_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
      .tx_enable(tx_enable), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
      .grant_id(grant_id)
   );

   task automatic do_reset();
      rst = 1'b1; req = '0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_slices(input logic [23:0] base);
      for (int i = 0; i < NREQ; i++) req_data[24*i +: 24] = base + 24'(i * 24'h010101);
   endtask

   // Waits for a frame start, then raises tx_done done_dly cycles after tx_enable
   // (0 = never) and captures the first ack/err response.
   task automatic run_frame(input int done_dly, output bit got_en, output int en_wait,
                            output logic [2:0] gid, output logic [23:0] data,
                            output logic [NREQ-1:0] ack_s, output logic [NREQ-1:0] err_s,
                            output int lat, output bit stable);
      got_en = 1'b0; en_wait = -1; gid = '0; data = '0;
      ack_s = '0; err_s = '0; lat = -1; stable = 1'b1;
      for (int k = 0; k < 40 && !got_en; k++) begin
         @(negedge clk);
         if (tx_enable === 1'b1) begin got_en = 1'b1; en_wait = k; end
      end
      if (!got_en) return;
      gid = grant_id; data = tx_data;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (tx_data !== data || grant_id !== gid || tx_enable !== 1'b0) stable = 1'b0;
         if ((ack | err) !== '0) begin ack_s = ack; err_s = err; lat = k; break; end
         if (done_dly > 0 && k == done_dly) tx_done = 1'b1;
      end
      tx_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; tx_done = 1'b0; req_data = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL reset_tx_enable: got %b want 0", tx_enable); end
      n_checks++; if (ack !== '0 || err !== '0) begin n_fail++; $display("FAIL reset_ack_err: got ack=%b err=%b want 0", ack, err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (tx_data !== 24'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 000000", tx_data); end
      n_checks++; if (grant_id !== 3'(NREQ-1)) begin n_fail++; $display("FAIL reset_grant_id: got %0d want %0d", grant_id, NREQ-1); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit en, st; int ew, lat; logic [2:0] gid; logic [23:0] d; logic [NREQ-1:0] a, e;
      exp_t x;
      do_reset();
      set_slices(24'h102030);
      req_data[23:0] = 24'hA1B2C3;
      req = 4'b0001;
      exp_q.push_back('{id: 3'd0, data: 24'hA1B2C3, is_err: 1'b0, lat: 51});
      fork
         run_frame(50, en, ew, gid, d, a, e, lat, st);
         begin
            repeat (3) @(negedge clk);
            req_data[23:0] = 24'h000000;
            req = '0;
         end
      join
      x = exp_q.pop_front();
      n_checks++; if (ew != 0) begin n_fail++; $display("FAIL single_en_latency: got %0d want 0", ew); end
      n_checks++; if (!en || gid !== x.id || d !== x.data) begin n_fail++; $display("FAIL single_grant: got en=%0d id=%0d data=%h want id=%0d data=%h", en, gid, d, x.id, x.data); end
      n_checks++; if (a !== 4'b0001 || e !== 4'b0000) begin n_fail++; $display("FAIL single_ack: got ack=%b err=%b want ack=0001 err=0000", a, e); end
      n_checks++; if (lat != x.lat) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, x.lat); end
      n_checks++; if (!st) begin n_fail++; $display("FAIL single_stable: got unstable tx_data/grant_id/tx_enable want stable"); end
      @(negedge clk);
      n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
      repeat (GAP - 2) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b want 1", busy); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", busy); end
      n_checks++; if (tx_data !== 24'hA1B2C3) begin n_fail++; $display("FAIL single_hold: got %h want a1b2c3", tx_data); end
   endtask

   task automatic test_round_robin();
      bit en, st; int ew, lat; logic [2:0] gid; logic [23:0] d; logic [NREQ-1:0] a, e;
      int cnt[NREQ]; exp_t x; int ids[5];
      ids = '{0, 1, 2, 3, 0};
      do_reset();
      set_slices(24'h5A0000);
      foreach (cnt[i]) cnt[i] = 0;
      req = 4'b1111;
      for (int f = 0; f < 5; f++)
         exp_q.push_back('{id: 3'(ids[f]), data: 24'h5A0000 + 24'(ids[f] * 24'h010101), is_err: 1'b0, lat: 4 + f});
      for (int f = 0; f < 5; f++) begin
         run_frame(3 + f, en, ew, gid, d, a, e, lat, st);
         if (f == 4) req = '0;
         if (f < 4) for (int i = 0; i < NREQ; i++) if (a[i] === 1'b1) cnt[i]++;
         x = exp_q.pop_front();
         n_checks++; if (!en || gid !== x.id || d !== x.data) begin n_fail++; $display("FAIL rr_grant%0d: got en=%0d id=%0d data=%h want id=%0d data=%h", f, en, gid, d, x.id, x.data); end
         n_checks++; if (a !== (4'b0001 << x.id) || e !== '0 || lat != x.lat) begin n_fail++; $display("FAIL rr_ack%0d: got ack=%b err=%b lat=%0d want ack=%b err=0000 lat=%0d", f, a, e, lat, 4'b0001 << x.id, x.lat); end
      end
      for (int i = 0; i < NREQ; i++) begin
         n_checks++; if (cnt[i] != 1) begin n_fail++; $display("FAIL rr_ack_count%0d: got %0d want 1", i, cnt[i]); end
      end
   endtask

   task automatic test_rr_skip();
      bit en, st; int ew, lat; logic [2:0] gid; logic [23:0] d; logic [NREQ-1:0] a, e;
      exp_t x; int ids[3];
      ids = '{1, 2, 0};
      do_reset();
      set_slices(24'h3C3C00);
      req = 4'b0010;
      for (int f = 0; f < 3; f++)
         exp_q.push_back('{id: 3'(ids[f]), data: 24'h3C3C00 + 24'(ids[f] * 24'h010101), is_err: 1'b0, lat: 5});
      for (int f = 0; f < 3; f++) begin
         run_frame(4, en, ew, gid, d, a, e, lat, st);
         if (f == 0) req = 4'b0101;
         if (f == 2) req = '0;
         x = exp_q.pop_front();
         n_checks++; if (!en || gid !== x.id || d !== x.data) begin n_fail++; $display("FAIL skip_grant%0d: got en=%0d id=%0d data=%h want id=%0d data=%h", f, en, gid, d, x.id, x.data); end
         n_checks++; if (a !== (4'b0001 << x.id) || e !== '0 || lat != x.lat) begin n_fail++; $display("FAIL skip_ack%0d: got ack=%b err=%b lat=%0d want ack=%b lat=%0d", f, a, e, lat, 4'b0001 << x.id, x.lat); end
      end
   endtask

   task automatic test_timeout();
      bit en, st; int ew, lat; logic [2:0] gid; logic [23:0] d; logic [NREQ-1:0] a, e;
      logic [NREQ-1:0] oh; exp_t x; int dly[2];
      dly = '{0, TMO};
      do_reset();
      set_slices(24'hE00000);
      req = 4'b0011;
      exp_q.push_back('{id: 3'd0, data: 24'hE00000, is_err: 1'b1, lat: TMO + 1});
      exp_q.push_back('{id: 3'd1, data: 24'hE10101, is_err: 1'b0, lat: TMO + 1});
      for (int f = 0; f < 2; f++) begin
         run_frame(dly[f], en, ew, gid, d, a, e, lat, st);
         req = (f == 0) ? 4'b0010 : 4'b0000;
         x = exp_q.pop_front();
         oh = 4'b0001 << x.id;
         n_checks++; if (!en || gid !== x.id || d !== x.data) begin n_fail++; $display("FAIL tmo_grant%0d: got en=%0d id=%0d data=%h want id=%0d data=%h", f, en, gid, d, x.id, x.data); end
         n_checks++; if (a !== (x.is_err ? 4'b0000 : oh) || e !== (x.is_err ? oh : 4'b0000)) begin n_fail++; $display("FAIL tmo_resp%0d: got ack=%b err=%b want ack=%b err=%b", f, a, e, x.is_err ? 4'b0000 : oh, x.is_err ? oh : 4'b0000); end
         n_checks++; if (lat != x.lat) begin n_fail++; $display("FAIL tmo_latency%0d: got %0d want %0d", f, lat, x.lat); end
      end
   endtask

   task automatic test_level_held();
      bit en; int extra; exp_t x;
      do_reset();
      set_slices(24'h777000);
      tx_done = 1'b1;
      @(negedge clk);
      req = 4'b0100;
      exp_q.push_back('{id: 3'd2, data: 24'h777000 + 24'h020202, is_err: 1'b0, lat: 0});
      en = 1'b0;
      for (int k = 0; k < 40 && !en; k++) begin @(negedge clk); if (tx_enable === 1'b1) en = 1'b1; end
      x = exp_q.pop_front();
      n_checks++; if (!en || grant_id !== x.id || tx_data !== x.data) begin n_fail++; $display("FAIL held_grant: got en=%0d id=%0d data=%h want id=%0d data=%h", en, grant_id, tx_data, x.id, x.data); end
      extra = 0;
      repeat (20) begin @(negedge clk); if ((ack | err) !== '0) extra++; end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL held_no_ack: got %0d responses want 0", extra); end
      tx_done = 1'b0;
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      n_checks++; if (ack !== 4'b0100 || err !== '0) begin n_fail++; $display("FAIL held_ack: got ack=%b err=%b want ack=0100 err=0000", ack, err); end
      req = '0;
      extra = 0;
      repeat (10) begin @(negedge clk); if ((ack | err) !== '0) extra++; end
      tx_done = 1'b0;
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL held_single_ack: got %0d extra responses want 0", extra); end
   endtask

   task automatic test_mid_reset();
      bit en; int got;
      set_slices(24'h900000);
      req = 4'b1111;
      en = 1'b0;
      for (int k = 0; k < 40 && !en; k++) begin @(negedge clk); if (tx_enable === 1'b1) en = 1'b1; end
      n_checks++; if (!en || grant_id !== 3'd3) begin n_fail++; $display("FAIL mr_pre_grant: got en=%0d id=%0d want id=3", en, grant_id); end
      repeat (5) @(negedge clk);
      rst = 1'b1; tx_done = 1'b1;
      @(negedge clk);
      n_checks++; if (ack !== '0 || err !== '0 || tx_enable !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mr_outputs: got ack=%b err=%b en=%b busy=%b want all 0", ack, err, tx_enable, busy); end
      n_checks++; if (tx_data !== 24'h0 || grant_id !== 3'd3) begin n_fail++; $display("FAIL mr_regs: got data=%h id=%0d want 000000 and 3", tx_data, grant_id); end
      rst = 1'b0; tx_done = 1'b0;
      @(negedge clk);
      n_checks++; if (tx_enable !== 1'b1 || grant_id !== 3'd0 || tx_data !== 24'h900000) begin n_fail++; $display("FAIL mr_first_grant: got en=%b id=%0d data=%h want 1 0 900000", tx_enable, grant_id, tx_data); end
      repeat (3) @(negedge clk);
      tx_done = 1'b1;
      got = 0;
      for (int k = 0; k < 5 && got == 0; k++) begin
         @(negedge clk);
         if ((ack | err) !== '0) got = 1;
      end
      n_checks++; if (ack !== 4'b0001 || err !== '0) begin n_fail++; $display("FAIL mr_ack: got ack=%b err=%b want ack=0001 err=0000", ack, err); end
      req = '0; tx_done = 1'b0;
      repeat (GAP + 2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_rr_skip();
      test_timeout();
      test_level_held();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 NREQ, 4, number of requesters (2..8).
REQ-002 GAP_CYC, 16, idle cycles enforced between frames (0 allowed).
REQ-003 TIMEOUT_CYC, 2000000, max WAIT cycles for tx_done before abort (>=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  NREQ  per-requester level request; held until ack/err.
REQ-007 req_data  input  24*NREQ  requester i frame at bits [24i+23:24i].
REQ-008 ack  output  NREQ  one-cycle pulse: frame of requester i completed.
REQ-009 err  output  NREQ  one-cycle pulse: frame of requester i aborted on timeout.
REQ-010 tx_enable  output  1  registered one-cycle start pulse to the 3-byte frame transmitter.
REQ-011 tx_data  output  24  frame to transmit; stable from tx_enable until the frame ends.
REQ-012 tx_done  input  1  transmitter completion; only its rising edge is significant.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_id  output  3  index of the current or most recent grant.

Function
REQ-015 FSM states: IDLE, START, WAIT, GAP; one-hot or binary, registered.
REQ-016 IDLE: any req bit high at clock edge n -> select winner, latch grant_id and tx_data from its req_data slice, enter START; tx_enable=1 during cycle n+1 only.
REQ-017 Round robin: search starts at (last_grant+1) mod NREQ, ascending with wrap; last_grant updated on every grant.
REQ-018 START: lasts exactly one cycle, clears timeout counter, goes to WAIT.
REQ-019 tx_done edge detect: registered previous value; edge = tx_done & ~tx_done_d; level held high from before START never counts.
REQ-020 WAIT: edge detected in cycle m -> ack[grant_id]=1 in cycle m+1 (one cycle), state GAP in m+1.
REQ-021 Timeout: counter increments each WAIT cycle, saturating width ceil(log2(TIMEOUT_CYC))+1; on reaching TIMEOUT_CYC without edge -> err[grant_id] one-cycle pulse, no ack, go GAP.
REQ-022 Edge and timeout in same cycle: completion wins; ack only.
REQ-023 GAP: counts GAP_CYC cycles then IDLE; GAP_CYC=0 -> IDLE on next cycle; req ignored during GAP.
REQ-024 req_data changes and req deassertion after grant are ignored; frame completes and ack still issues.
REQ-025 At most one bit of (ack | err) high in any cycle; ack and err never both high.
REQ-026 Requester still requesting after its ack is re-eligible after GAP, behind all other pending requesters.
REQ-027 tx_data and grant_id hold their values outside START/WAIT until next grant.

Reset
REQ-028 rst high at a clock edge: state IDLE, tx_enable=0, ack=0, err=0, busy=0, tx_data=0, grant_id=NREQ-1, last_grant=NREQ-1, all counters 0, tx_done_d=0.
REQ-029 rst has priority over every other condition, including mid-frame; mid-frame reset emits no ack or err.
REQ-030 After reset, requester 0 has highest priority.

Verification
REQ-031 req=0001, slice0=0xA1B2C3, tx_done rises 50 cycles after tx_enable -> tx_enable pulse 1 cycle after req sampled, tx_data=0xA1B2C3, ack=0001 one cycle after edge, busy low GAP_CYC+1 cycles later.
REQ-032 req=1111 held, each frame acked -> grant_id sequence 0,1,2,3,0; exactly one ack per requester per round.
REQ-033 last grant 1, req=0101 -> grant_id=2, then 0 on next round.
REQ-034 TIMEOUT_CYC=100, tx_done held 0 -> err[i] pulse after 100 WAIT cycles, no ack, next pending requester granted after GAP.
REQ-035 tx_done high before START and held -> no ack; after fall then rise -> single ack.
REQ-036 rst asserted during WAIT -> next cycle all outputs at reset values, no ack/err; subsequent req=1111 grants requester 0 first.
